traffic_phase_seq: RTL and testbench

TRAFFIC_PHASE_SEQ -- requirements
Module: traffic_phase_seq

---
 rtl/traffic_pkg.sv | 26 ++
 rtl/phase_timer.sv | 28 ++
 rtl/traffic_phase_seq.sv | 148 ++++++++++++++
 tb/tb_traffic_phase_seq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types for the traffic phase sequencer: phase encoding and light codes.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package traffic_pkg;

    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        RED_A       = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        RED_B       = 3'd5,
        PED_WALK    = 3'd6
    } phase_t;

    // Light outputs are one-hot {red,yellow,green}.
    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    // A duration is usable only if it is non-zero and its last count fits the timer.
    function automatic bit duration_ok(input int dur, input int width);
        return (dur > 0) && (dur < (1 << width));
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase timer: counts cycles in the current phase and flags the last one.
// Latency: tc is combinational from the count register; clear takes effect next edge.
// Backpressure: saturates at dur-1 until cleared, so a held phase never wraps.
module phase_timer #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [CNT_W-1:0] dur,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    assign tc = (count == (dur - CNT_W'(1)));

    // Count up each cycle, restart on clear, park on the terminal count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (!tc) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/traffic_phase_seq.sv
// Traffic intersection phase sequencer with pedestrian and side-road demand latches.
// Latency: requests are latched on the edge they are seen; phase advances the edge after its last cycle.
// Backpressure: none; a request is held pending until its phase is entered.
module traffic_phase_seq
    import traffic_pkg::*;
#(
    parameter int CNT_W       = 6,
    parameter int GREEN_T     = 11,
    parameter int YELLOW_T    = 2,
    parameter int RED_T       = 2,
    parameter int PED_T       = 10,
    parameter int SIDE_DEMAND = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ped_req,
    input  logic             side_req,
    output logic [2:0]       main_light,
    output logic [2:0]       side_light,
    output logic             walk,
    output logic             phase_done,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] count
);

    if (!duration_ok(GREEN_T, CNT_W) || !duration_ok(YELLOW_T, CNT_W) ||
        !duration_ok(RED_T, CNT_W)   || !duration_ok(PED_T, CNT_W)) begin : g_bad_duration
        $error("traffic_phase_seq: every duration must be non-zero and below 2**CNT_W");
    end

    localparam logic [CNT_W-1:0] GREEN_D  = CNT_W'(GREEN_T);
    localparam logic [CNT_W-1:0] YELLOW_D = CNT_W'(YELLOW_T);
    localparam logic [CNT_W-1:0] RED_D    = CNT_W'(RED_T);
    localparam logic [CNT_W-1:0] PED_D    = CNT_W'(PED_T);

    phase_t           state_q;
    phase_t           state_d;
    logic             ped_pending;
    logic             side_pending;
    logic [CNT_W-1:0] dur;
    logic             tc;
    logic             holding;
    logic             advance;

    // Pick the length of the phase currently running.
    always_comb begin
        dur = GREEN_D;
        case (state_q)
            MAIN_GREEN, SIDE_GREEN:   dur = GREEN_D;
            MAIN_YELLOW, SIDE_YELLOW: dur = YELLOW_D;
            RED_A, RED_B:             dur = RED_D;
            PED_WALK:                 dur = PED_D;
            default:                  dur = GREEN_D;
        endcase
    end

    // In demand mode main green parks at its last count until someone asks;
    // a raw request counts so the hold releases on the very edge it is seen.
    assign holding = (SIDE_DEMAND != 0) && (state_q == MAIN_GREEN) &&
                     !(ped_pending || side_pending || ped_req || side_req);
    assign advance = tc && !holding;

    // Gated by reset so a 1-cycle phase cannot show a pulse while reset is held.
    assign phase_done = advance && !reset;
    assign phase      = state_q;

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (advance),
        .dur   (dur),
        .count (count),
        .tc    (tc)
    );

    // Phase register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MAIN_GREEN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next phase and light decode.
    always_comb begin
        state_d    = state_q;
        main_light = LIGHT_RED;
        side_light = LIGHT_RED;
        walk       = 1'b0;
        case (state_q)
            MAIN_GREEN: begin
                main_light = LIGHT_GREEN;
                if (advance) state_d = MAIN_YELLOW;
            end
            MAIN_YELLOW: begin
                main_light = LIGHT_YELLOW;
                if (advance) state_d = RED_A;
            end
            RED_A: begin
                if (advance) state_d = SIDE_GREEN;
            end
            SIDE_GREEN: begin
                side_light = LIGHT_GREEN;
                if (advance) state_d = SIDE_YELLOW;
            end
            SIDE_YELLOW: begin
                side_light = LIGHT_YELLOW;
                if (advance) state_d = RED_B;
            end
            RED_B: begin
                if (advance) state_d = ped_pending ? PED_WALK : MAIN_GREEN;
            end
            PED_WALK: begin
                walk = 1'b1;
                if (advance) state_d = MAIN_GREEN;
            end
            default: begin
                state_d = MAIN_GREEN;
            end
        endcase
    end

    // Pedestrian latch: cleared on entry to the walk (clear beats a coincident request).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ped_pending <= 1'b0;
        end else if (advance && (state_q == RED_B) && ped_pending) begin
            ped_pending <= 1'b0;
        end else if (ped_req && (state_q != PED_WALK)) begin
            ped_pending <= 1'b1;
        end
    end

    // Side-road latch: cleared on entry to side green (clear beats a coincident request).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            side_pending <= 1'b0;
        end else if (advance && (state_q == RED_A)) begin
            side_pending <= 1'b0;
        end else if (side_req) begin
            side_pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_traffic_phase_seq.sv
// Directed bench for traffic_phase_seq: default timing, ped walk, demand hold, async reset.
// Latency: outputs sampled on the falling edge; cycle 0 is the first cycle after reset release.
// Backpressure: not applicable.
module tb_traffic_phase_seq;
    import traffic_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ped_req = 1'b0;
    logic       side_req = 1'b0;

    logic [2:0] ml0, sl0, ph0, ml1, sl1, ph1;
    logic       walk0, done0, walk1, done1;
    logic [5:0] cnt0, cnt1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    traffic_phase_seq u_dut0 (
        .clk        (clk),
        .reset      (reset),
        .ped_req    (ped_req),
        .side_req   (side_req),
        .main_light (ml0),
        .side_light (sl0),
        .walk       (walk0),
        .phase_done (done0),
        .phase      (ph0),
        .count      (cnt0)
    );

    traffic_phase_seq #(.SIDE_DEMAND(1)) u_dut1 (
        .clk        (clk),
        .reset      (reset),
        .ped_req    (ped_req),
        .side_req   (side_req),
        .main_light (ml1),
        .side_light (sl1),
        .walk       (walk1),
        .phase_done (done1),
        .phase      (ph1),
        .count      (cnt1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    // Expected behaviour of a default-timed, request-free 30-cycle round.
    function automatic logic [2:0] ref_phase(input int m);
        if (m < 11)      return 3'd0;
        else if (m < 13) return 3'd1;
        else if (m < 15) return 3'd2;
        else if (m < 26) return 3'd3;
        else if (m < 28) return 3'd4;
        else             return 3'd5;
    endfunction

    function automatic int ref_start(input int m);
        if (m < 11)      return 0;
        else if (m < 13) return 11;
        else if (m < 15) return 13;
        else if (m < 26) return 15;
        else if (m < 28) return 26;
        else             return 28;
    endfunction

    function automatic logic ref_done(input int m);
        return (m == 10) || (m == 12) || (m == 14) || (m == 25) || (m == 27) || (m == 29);
    endfunction

    // Advance to the next falling edge and check light invariants on both instances.
    task automatic step();
        @(negedge clk);
        cyc++;
        check("onehot_main0", $onehot(ml0), 1);
        check("onehot_side0", $onehot(sl0), 1);
        check("no_conflict0", (ml0 == LIGHT_RED) || (sl0 == LIGHT_RED), 1);
        check("onehot_main1", $onehot(ml1), 1);
        check("onehot_side1", $onehot(sl1), 1);
        check("no_conflict1", (ml1 == LIGHT_RED) || (sl1 == LIGHT_RED), 1);
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    // Hold reset for two edges, release just after a rising edge; returns at cycle 0.
    task automatic do_reset();
        reset    = 1'b1;
        ped_req  = 1'b0;
        side_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        cyc = -1;
        step();
    endtask

    // Default instance with one walk occupying cycles 30..39.
    task automatic check_walk_round(input string tag);
        int m;
        if (cyc < 30) begin
            check({tag, "_phase"}, ph0, ref_phase(cyc));
            check({tag, "_done"}, done0, ref_done(cyc));
            check({tag, "_walk"}, walk0, 0);
        end else if (cyc < 40) begin
            check({tag, "_phase"}, ph0, 3'd6);
            check({tag, "_count"}, cnt0, cyc - 30);
            check({tag, "_done"}, done0, cyc == 39);
            check({tag, "_walk"}, walk0, 1);
            check({tag, "_lights"}, {ml0, sl0}, {LIGHT_RED, LIGHT_RED});
        end else begin
            m = (cyc - 40) % 30;
            check({tag, "_phase"}, ph0, ref_phase(m));
            check({tag, "_count"}, cnt0, m - ref_start(m));
            check({tag, "_done"}, done0, ref_done(m));
            check({tag, "_walk"}, walk0, 0);
        end
    endtask

    initial begin
        // Reset state, asserted without any clock edge.
        #1 reset = 1'b1;
        #1;
        check("rst_phase", ph0, 3'd0);
        check("rst_count", cnt0, 0);
        check("rst_main", ml0, 3'b001);
        check("rst_side", sl0, 3'b100);
        check("rst_walk", walk0, 0);
        check("rst_done", done0, 0);

        // Default timing, no requests: 30-cycle round repeated twice.
        do_reset();
        for (int i = 0; i < 60; i++) begin
            check("idle_phase", ph0, ref_phase(cyc % 30));
            check("idle_count", cnt0, (cyc % 30) - ref_start(cyc % 30));
            check("idle_done", done0, ref_done(cyc % 30));
            check("idle_walk", walk0, 0);
            step();
        end

        // Pedestrian pulse at cycle 3: walk at 30..39, main green again at 40.
        do_reset();
        for (int i = 0; i < 46; i++) begin
            check_walk_round("ped");
            ped_req = (cyc == 3);
            step();
        end
        ped_req = 1'b0;

        // ped_req held 25..39: the coincident clear at 29 wins and the request is
        // ignored during the walk, so the next round has no walk (main green at 70).
        do_reset();
        for (int i = 0; i < 76; i++) begin
            check_walk_round("held");
            ped_req = (cyc >= 25) && (cyc <= 39);
            step();
        end
        ped_req = 1'b0;

        // Demand mode: main green parks at count 10 with no pulse until side_req.
        do_reset();
        for (int i = 0; i < 101; i++) begin
            check("hold_phase", ph1, 3'd0);
            check("hold_count", cnt1, (cyc < 10) ? cyc : 10);
            check("hold_done", done1, 0);
            if (cyc < 100) step();
        end
        side_req = 1'b1;
        #1 check("hold_release_done", done1, 1);
        step();
        side_req = 1'b0;
        check("demand_yellow", ph1, 3'd1);
        check("demand_yellow_count", cnt1, 0);
        run_to(105);
        check("demand_side_green", ph1, 3'd3);
        check("demand_side_light", sl1, LIGHT_GREEN);
        run_to(120);
        check("demand_back_main", ph1, 3'd0);
        run_to(130);
        check("demand_rehold_count", cnt1, 10);
        check("demand_rehold_done", done1, 0);

        // Reset at cycle 33 of a walk: outputs return before any clock edge.
        do_reset();
        ped_req = 1'b1;
        step();
        run_to(3);
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        run_to(33);
        check("mid_walk_phase", ph0, 3'd6);
        check("mid_walk_count", cnt0, 3);
        #1 reset = 1'b1;
        #1;
        check("async_phase", ph0, 3'd0);
        check("async_count", cnt0, 0);
        check("async_main", ml0, 3'b001);
        check("async_side", sl0, 3'b100);
        check("async_walk", walk0, 0);
        check("async_done", done0, 0);
        do_reset();
        check("post_rst_phase", ph0, 3'd0);
        check("post_rst_count", cnt0, 0);
        run_to(30);
        check("post_rst_no_walk", ph0, 3'd0);

        // Reset while a pedestrian request is pending drops the request.
        do_reset();
        run_to(3);
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        run_to(20);
        do_reset();
        run_to(30);
        check("pend_cleared_phase", ph0, 3'd0);
        check("pend_cleared_walk", walk0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
